// File: rtl/fetch_uni.sv
// rtl/fetch_uni.sv - LEGv8 instruction fetch stage with req/ready imem handshake
//
// Purpose:
//   Owns the PC, fetches one instruction at a time from a variable-latency
//   instruction memory, presents it to decode/control for one issue window,
//   then advances the PC sequentially or by a CBZ/CBNZ/B.cond displacement.
//   Outside the issue window the instruction bus is all-zero (a no-op bubble).
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   When defined, retired and taken-branch counters are built.
//   When undefined, oRETIRED/oTAKEN are tied to zero.
//
// Ports:
//   iCLK, iRST          clock (rising edge), asynchronous active-high reset
//   oIMEM_REQ           fetch request, held until iIMEM_READY
//   oIMEM_ADDR          fetch address (current PC)
//   iIMEM_READY         instruction memory data valid this cycle
//   iIMEM_DATA          instruction word from memory
//   oVALID              instruction is in its issue window
//   oINSTR, oOPCODE     issued instruction and its [31:21] opcode, 0 when idle
//   oPC                 PC of the issued instruction
//   iSTALL              holds the issue window
//   iBRANCH             branch class: 00 none, 01 CBZ/CBNZ, 10 B.cond, 11 none
//   iZERO, iCOND_TRUE   ALU zero flag and B.cond result for the issued instr
//   oRETIRED, oTAKEN    performance counters

module fetch_uni #(
  parameter int                   PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                iCLK,
  input  logic                iRST,
  output logic                oIMEM_REQ,
  output logic [PC_WIDTH-1:0] oIMEM_ADDR,
  input  logic                iIMEM_READY,
  input  logic [31:0]         iIMEM_DATA,
  output logic                oVALID,
  output logic [31:0]         oINSTR,
  output logic [10:0]         oOPCODE,
  output logic [PC_WIDTH-1:0] oPC,
  input  logic                iSTALL,
  input  logic [1:0]          iBRANCH,
  input  logic                iZERO,
  input  logic                iCOND_TRUE,
  output logic [31:0]         oRETIRED,
  output logic [31:0]         oTAKEN
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} stateT;

  // Instructions are word aligned, so the low two reset bits are discarded.
  localparam logic [PC_WIDTH-1:0] RESET_PC_ALIGNED = {RESET_PC[PC_WIDTH-1:2], 2'b00};

  stateT               state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] branchOffset;
  logic [PC_WIDTH-1:0] nextPc;
  logic                taken;
  logic                issueExit;

  // The instruction register doubles as oINSTR; it is cleared on every ISSUE
  // exit so the bus carries a zero bubble whenever oVALID is low.
  assign oOPCODE    = oINSTR[31:21];
  assign oIMEM_ADDR = pc;
  assign oPC        = pc;
  assign issueExit  = (state == ISSUE) && !iSTALL;

  // Branch resolution. instr[24] separates CBNZ (1) from CBZ (0).
  always_comb begin
    taken = 1'b0;
    case (iBRANCH)
      2'b01:   taken = oINSTR[24] ? !iZERO : iZERO;
      2'b10:   taken = iCOND_TRUE;
      default: taken = 1'b0;
    endcase
  end

  // imm19 at instr[23:5], sign-extended and scaled to a byte offset.
  assign branchOffset = {{(PC_WIDTH-21){oINSTR[23]}}, oINSTR[23:5], 2'b00};
  assign nextPc       = pc + (taken ? branchOffset : PC_WIDTH'(4));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state     <= IDLE;
      pc        <= RESET_PC_ALIGNED;
      oIMEM_REQ <= 1'b0;
      oVALID    <= 1'b0;
      oINSTR    <= '0;
    end else begin
      case (state)
        IDLE: begin
          state     <= FETCH;
          oIMEM_REQ <= 1'b1;
        end
        FETCH: begin
          if (iIMEM_READY) begin
            oINSTR    <= iIMEM_DATA;
            oVALID    <= 1'b1;
            oIMEM_REQ <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!iSTALL) begin
            pc        <= nextPc;
            oINSTR    <= '0;
            oVALID    <= 1'b0;
            oIMEM_REQ <= 1'b1;
            state     <= FETCH;
          end
        end
        default: begin
          state     <= IDLE;
          oIMEM_REQ <= 1'b0;
          oVALID    <= 1'b0;
          oINSTR    <= '0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retiredCnt;
  logic [31:0] takenCnt;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      retiredCnt <= '0;
      takenCnt   <= '0;
    end else if (issueExit) begin
      retiredCnt <= retiredCnt + 32'd1;
      if (taken) begin
        takenCnt <= takenCnt + 32'd1;
      end
    end
  end

  assign oRETIRED = retiredCnt;
  assign oTAKEN   = takenCnt;
`else
  assign oRETIRED = '0;
  assign oTAKEN   = '0;
`endif

endmodule

// File: tb/tb_fetch_uni.sv
// tb/tb_fetch_uni.sv - directed scoreboard bench for fetch_uni

module tb_fetch_uni;

  localparam int          PC_WIDTH = 64;
  localparam logic [63:0] RST_PC   = 64'h40;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        oIMEM_REQ;
  logic [63:0] oIMEM_ADDR;
  logic        iIMEM_READY;
  logic [31:0] iIMEM_DATA;
  logic        oVALID;
  logic [31:0] oINSTR;
  logic [10:0] oOPCODE;
  logic [63:0] oPC;
  logic        iSTALL;
  logic [1:0]  iBRANCH;
  logic        iZERO;
  logic        iCOND_TRUE;
  logic [31:0] oRETIRED;
  logic [31:0] oTAKEN;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } expT;

  expT         sbQ[$];
  logic [63:0] tbPc;
  int          passCnt = 0;
  int          failCnt = 0;
  int          totalCnt = 0;

  fetch_uni #(.PC_WIDTH(PC_WIDTH), .RESET_PC(RST_PC)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .oIMEM_REQ(oIMEM_REQ), .oIMEM_ADDR(oIMEM_ADDR),
    .iIMEM_READY(iIMEM_READY), .iIMEM_DATA(iIMEM_DATA),
    .oVALID(oVALID), .oINSTR(oINSTR), .oOPCODE(oOPCODE), .oPC(oPC),
    .iSTALL(iSTALL), .iBRANCH(iBRANCH), .iZERO(iZERO), .iCOND_TRUE(iCOND_TRUE),
    .oRETIRED(oRETIRED), .oTAKEN(oTAKEN)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serve one fetch: wait for REQ, hold READY low for 'delay' cycles while
  // checking the request is stable, then return 'data' and log the expectation.
  task automatic doFetch(input int delay, input logic [31:0] data);
    int waitCyc = 0;
    while (oIMEM_REQ !== 1'b1 && waitCyc < 20) begin
      @(negedge iCLK);
      waitCyc++;
    end
    chk("fetch_req", 64'(oIMEM_REQ), 64'd1);
    chk("fetch_addr", oIMEM_ADDR, tbPc);
    chk("fetch_valid_low", 64'(oVALID), 64'd0);
    chk("fetch_opcode_zero", 64'(oOPCODE), 64'd0);
    iIMEM_READY = 1'b0;
    for (int i = 0; i < delay; i++) begin
      @(negedge iCLK);
      chk("req_hold", 64'(oIMEM_REQ), 64'd1);
      chk("addr_hold", oIMEM_ADDR, tbPc);
      chk("opcode_zero_wait", 64'(oOPCODE), 64'd0);
    end
    iIMEM_READY = 1'b1;
    iIMEM_DATA  = data;
    sbQ.push_back('{pc: tbPc, instr: data});
    @(negedge iCLK);
    iIMEM_READY = 1'b0;
    iIMEM_DATA  = $urandom;
  endtask

  // Check the issue window against the scoreboard, optionally stall with
  // random branch noise, then retire with the given branch inputs.
  task automatic doIssue(input int stalls, input logic [1:0] br, input logic z,
                         input logic c, input logic [63:0] expNext);
    expT         e;
    logic [31:0] w;
    chk("issue_valid", 64'(oVALID), 64'd1);
    chk("sb_nonempty", 64'(sbQ.size() > 0), 64'd1);
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      w = e.instr;
      chk("issue_pc", oPC, e.pc);
      chk("issue_instr", 64'(oINSTR), 64'(w));
      chk("issue_opcode", 64'(oOPCODE), 64'(w[31:21]));
      chk("issue_req_low", 64'(oIMEM_REQ), 64'd0);
      for (int i = 0; i < stalls; i++) begin
        iSTALL     = 1'b1;
        iBRANCH    = 2'($urandom);
        iZERO      = 1'($urandom);
        iCOND_TRUE = 1'($urandom);
        @(negedge iCLK);
        chk("stall_valid", 64'(oVALID), 64'd1);
        chk("stall_instr", 64'(oINSTR), 64'(w));
        chk("stall_pc", oPC, e.pc);
        chk("stall_req", 64'(oIMEM_REQ), 64'd0);
      end
    end
    iSTALL     = 1'b0;
    iBRANCH    = br;
    iZERO      = z;
    iCOND_TRUE = c;
    @(negedge iCLK);
    iBRANCH    = 2'b00;
    iZERO      = 1'b0;
    iCOND_TRUE = 1'b0;
    chk("bubble_valid", 64'(oVALID), 64'd0);
    chk("bubble_instr", 64'(oINSTR), 64'd0);
    chk("bubble_opcode", 64'(oOPCODE), 64'd0);
    tbPc = expNext;
  endtask

  initial begin
    iRST = 1'b1;
    iIMEM_READY = 1'b1;
    iIMEM_DATA = 32'h0;
    iSTALL = 1'b0;
    iBRANCH = 2'b00;
    iZERO = 1'b0;
    iCOND_TRUE = 1'b0;
    tbPc = RST_PC;

    repeat (2) @(negedge iCLK);
    chk("rst_req", 64'(oIMEM_REQ), 64'd0);
    chk("rst_valid", 64'(oVALID), 64'd0);
    chk("rst_instr", 64'(oINSTR), 64'd0);
    chk("rst_addr", oIMEM_ADDR, 64'h40);
    chk("rst_retired", 64'(oRETIRED), 64'd0);
    chk("rst_taken", 64'(oTAKEN), 64'd0);

    iRST = 1'b0;
    @(negedge iCLK);
    chk("req_first_cycle", 64'(oIMEM_REQ), 64'd1);
    chk("addr_first_cycle", oIMEM_ADDR, 64'h40);

    // ADD at 0x40, zero latency
    doFetch(0, 32'h8B020020);
    doIssue(0, 2'b00, 1'b0, 1'b0, 64'h44);
    // ADD at 0x44, 3-cycle latency
    doFetch(3, 32'h8B020020);
    chk("add_opcode", 64'(oOPCODE), 64'h458);
    doIssue(0, 2'b00, 1'b1, 1'b1, 64'h48);
    // B.cond at 0x48, imm19=46 -> 0x100
    doFetch(1, 32'h540005C0);
    doIssue(0, 2'b10, 1'b0, 1'b1, 64'h100);
    // CBZ at 0x100, imm19=-2, zero=1 -> 0xF8
    doFetch(2, 32'hB4FFFFC0);
    doIssue(0, 2'b01, 1'b1, 1'b0, 64'hF8);
    chk("cnt_retired_4", 64'(oRETIRED), PERF ? 64'd4 : 64'd0);
    chk("cnt_taken_2", 64'(oTAKEN), PERF ? 64'd2 : 64'd0);
    // B.cond at 0xF8, imm19=2, stalled 4 cycles -> 0x100
    doFetch(0, 32'h54000040);
    doIssue(4, 2'b10, 1'b0, 1'b1, 64'h100);
    // CBZ at 0x100, zero=0 -> 0x104
    doFetch(1, 32'hB4FFFFC0);
    doIssue(0, 2'b01, 1'b0, 1'b1, 64'h104);
    // CBNZ at 0x104, imm19=-3, zero=0 -> 0xF8
    doFetch(0, 32'hB5FFFFA0);
    doIssue(0, 2'b01, 1'b0, 1'b0, 64'hF8);
    // branch class 11 is not taken even with flags set -> 0xFC
    doFetch(0, 32'hB4FFFFC0);
    doIssue(0, 2'b11, 1'b1, 1'b1, 64'hFC);
    chk("cnt_retired_8", 64'(oRETIRED), PERF ? 64'd8 : 64'd0);
    chk("cnt_taken_4", 64'(oTAKEN), PERF ? 64'd4 : 64'd0);

    // reset mid-FETCH at 0xFC
    chk("pre_rst_req", 64'(oIMEM_REQ), 64'd1);
    chk("pre_rst_addr", oIMEM_ADDR, 64'hFC);
    iRST = 1'b1;
    #1;
    chk("async_req_drop", 64'(oIMEM_REQ), 64'd0);
    chk("async_valid_low", 64'(oVALID), 64'd0);
    chk("async_addr", oIMEM_ADDR, 64'h40);
    @(negedge iCLK);
    iRST = 1'b0;
    iIMEM_READY = 1'b1;
    iIMEM_DATA = 32'hDEADBEEF;
    @(negedge iCLK);
    iIMEM_READY = 1'b0;
    chk("refetch_req", 64'(oIMEM_REQ), 64'd1);
    chk("refetch_addr", oIMEM_ADDR, 64'h40);
    chk("stray_ready_ignored", 64'(oVALID), 64'd0);
    @(negedge iCLK);
    chk("still_fetching", 64'(oVALID), 64'd0);
    chk("cnt_cleared", 64'(oRETIRED), 64'd0);
    tbPc = RST_PC;
    doFetch(1, 32'h8B020020);
    doIssue(0, 2'b00, 1'b0, 1'b0, 64'h44);
    chk("post_rst_next_addr", oIMEM_ADDR, 64'h44);
    chk("sb_drained", 64'(sbQ.size()), 64'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
